// File: rtl/psubsb_seq_pkg.sv
// Purpose : shared widths, saturation constants and FSM encoding for the nibble-serial saturating subtractor.
// Latency : n/a (definitions only).
// Backpressure: n/a.
package psubsb_seq_pkg;

    localparam int LANE_W    = 4;
    localparam int NUM_LANES = 4;
    localparam int DATA_W    = LANE_W * NUM_LANES;
    localparam int CNT_W     = $clog2(NUM_LANES);

    localparam logic [LANE_W-1:0] SAT_POS = 4'b0111;
    localparam logic [LANE_W-1:0] SAT_NEG = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Data word viewed as an array of lanes; lane i occupies bits [LANE_W*i +: LANE_W].
    typedef logic [NUM_LANES-1:0][LANE_W-1:0] lanes_t;

endpackage

// File: rtl/psubsb_seq_if.sv
// Purpose : start/busy/done handshake plus operand/result bus between the execute stage and the subtractor.
// Latency : n/a (wiring only).
// Backpressure: none on the bus itself; the master must hold off while busy (start is ignored then).
// Signals : start, A, B (master -> unit); busy, done, Diff, sat_flags (unit -> master).
interface psubsb_seq_if;
    import psubsb_seq_pkg::*;

    logic                 start;
    logic [DATA_W-1:0]    A;
    logic [DATA_W-1:0]    B;
    logic                 busy;
    logic                 done;
    logic [DATA_W-1:0]    Diff;
    logic [NUM_LANES-1:0] sat_flags;

    modport master (
        output start, A, B,
        input  busy, done, Diff, sat_flags
    );

    modport slave (
        input  start, A, B,
        output busy, done, Diff, sat_flags
    );

endinterface

// File: rtl/psubsb_lane_4b.sv
// Purpose : one signed lane of saturating subtraction, out = clamp(a - b) to the signed lane range.
// Latency : combinational.
// Backpressure: none.
// Ports   : i_a, i_b (lane operands) -> o_out (clamped difference), o_sat (clamp occurred).
module psubsb_lane_4b
    import psubsb_seq_pkg::*;
(
    input  logic [LANE_W-1:0] i_a,
    input  logic [LANE_W-1:0] i_b,
    output logic [LANE_W-1:0] o_out,
    output logic              o_sat
);

    logic [LANE_W-1:0] w_r;
    logic              w_ovf;

    // Two's-complement subtract, wrapped to lane width.
    assign w_r = i_a + ~i_b + LANE_W'(1);

    // Overflow is only possible when the operand signs differ, and shows up as
    // a result whose sign disagrees with the minuend.
    assign w_ovf = (i_a[LANE_W-1] != i_b[LANE_W-1]) && (w_r[LANE_W-1] != i_a[LANE_W-1]);

    // Negative minuend can only overflow downward, positive only upward.
    assign o_out = w_ovf ? (i_a[LANE_W-1] ? SAT_NEG : SAT_POS) : w_r;
    assign o_sat = w_ovf;

endmodule

// File: rtl/psubsb_seq.sv
// Purpose : nibble-serial saturating A-B on four signed lanes, one lane per clock, single shared lane unit.
// Latency : accept edge, then 4 lane edges; done pulses in the 5th cycle after accept; one op per 6 cycles.
// Backpressure: start only sampled in IDLE; requests while busy are dropped, not queued.
// Ports   : clk, rst (sync, active-high); bus (slave side: start/A/B in, busy/done/Diff/sat_flags out).
module psubsb_seq
    import psubsb_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    psubsb_seq_if.slave  bus
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_lane_cnt;
    lanes_t               r_a;
    lanes_t               r_b;
    lanes_t               r_acc;
    lanes_t               w_acc_nxt;
    lanes_t               r_diff;
    logic [NUM_LANES-1:0] r_acc_sat;
    logic [NUM_LANES-1:0] w_acc_sat_nxt;
    logic [NUM_LANES-1:0] r_sat;
    logic                 w_accept;
    logic                 w_last_lane;
    logic                 w_busy;
    logic                 w_done;
    logic [LANE_W-1:0]    w_lane_out;
    logic                 w_lane_sat;

    assign w_last_lane = (r_lane_cnt == CNT_W'(NUM_LANES - 1));

    // Single lane unit, time-shared across lanes via lane_cnt.
    psubsb_lane_4b u_lane (
        .i_a   (r_a[r_lane_cnt]),
        .i_b   (r_b[r_lane_cnt]),
        .o_out (w_lane_out),
        .o_sat (w_lane_sat)
    );

    // Accumulator with the current lane merged in; on the last lane this is the
    // complete result, so outputs load from it and update all lanes at once.
    always_comb begin
        w_acc_nxt                 = r_acc;
        w_acc_sat_nxt             = r_acc_sat;
        w_acc_nxt[r_lane_cnt]     = w_lane_out;
        w_acc_sat_nxt[r_lane_cnt] = w_lane_sat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (w_last_lane) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane_cnt <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_acc_sat  <= '0;
            r_diff     <= '0;
            r_sat      <= '0;
        end else if (w_accept) begin
            // Operands are latched here so the master may change A/B while busy.
            r_a        <= bus.A;
            r_b        <= bus.B;
            r_lane_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_acc      <= w_acc_nxt;
            r_acc_sat  <= w_acc_sat_nxt;
            r_lane_cnt <= r_lane_cnt + CNT_W'(1);
            if (w_last_lane) begin
                r_diff <= w_acc_nxt;
                r_sat  <= w_acc_sat_nxt;
            end
        end
    end

    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.Diff      = r_diff;
    assign bus.sat_flags = r_sat;

endmodule
